// File: rtl/wb_rom_pipe.sv
// wb_rom_pipe: read-only program/data ROM behind a Wishbone B4 pipelined
// slave port. Fixed accept-to-ack latency (LATENCY stages), one request per
// cycle, error termination for writes and out-of-range addresses, and all
// in-flight terminations dropped when the master releases wb_cyc_i.
module wb_rom_pipe #(
  parameter int unsigned SIZE       = 'h1000,
  parameter int unsigned ADDR_WIDTH = $clog2(SIZE),
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LATENCY    = 1,   // legal 1..4
  parameter              INIT_FILE  = "j1.mif"
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [ADDR_WIDTH-1:0] wb_adr_i,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic                  wb_stall_o
);

  // ROM storage; contents come from INIT_FILE at configuration time and are
  // never written by this block.
  (* ram_init_file = INIT_FILE *)
  logic [DATA_WIDTH-1:0] mem [SIZE];

  logic                  accept;
  logic                  bad;
  logic [LATENCY-1:0]    vld_q, vld_d;
  logic [LATENCY-1:0]    err_q, err_d;
  logic [DATA_WIDTH-1:0] dat_q [LATENCY];
  logic                  term;

  // No backpressure: the only time we refuse requests is while in reset.
  assign wb_stall_o = reset;
  assign accept     = wb_cyc_i & wb_stb_i & ~wb_stall_o;
  // SIZE need not be a power of two, so the range check is explicit.
  assign bad        = wb_we_i | (32'(wb_adr_i) >= SIZE);

  // Next-state for the valid/error shift chain; dropping cyc kills every
  // pending termination so nothing stale leaks into the next bus cycle.
  always_comb begin
    vld_d    = '0;
    err_d    = '0;
    vld_d[0] = accept;
    err_d[0] = accept & bad;
    for (int k = 1; k < LATENCY; k++) begin
      vld_d[k] = vld_q[k-1] & wb_cyc_i;
      err_d[k] = err_q[k-1];
    end
  end

  // Valid/error pipeline register, cleared asynchronously by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      err_q <= '0;
    end else begin
      vld_q <= vld_d;
      err_q <= err_d;
    end
  end

  // Data pipeline: unreset, clock-enabled so bad requests never touch the
  // array and idle stages hold their value.
  always_ff @(posedge clock) begin
    if (accept & ~bad) dat_q[0] <= mem[wb_adr_i];
    for (int k = 1; k < LATENCY; k++)
      if (vld_q[k-1]) dat_q[k] <= dat_q[k-1];
  end

  // Terminations are gated by the live cyc so an abort masks them this cycle.
  assign term     = vld_q[LATENCY-1] & wb_cyc_i;
  assign wb_ack_o = term & ~err_q[LATENCY-1];
  assign wb_err_o = term &  err_q[LATENCY-1];
  assign wb_dat_o = wb_ack_o ? dat_q[LATENCY-1] : '0;

endmodule
